// File: rtl/counter_pkg.sv
// counter_pkg - shared types and helpers for the mode counter bank
//  dir_e      : counting direction encoding (DIR_DOWN=0, DIR_UP=1)
//  clamp_max  : returns min(val, max); used to bound load values
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic logic [31:0] clamp_max(input logic [31:0] val, input logic [31:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/counter_chan.sv
// counter_chan - one modulo/saturating counter channel with registered terminal pulse
//  clk, rst_n  : clock, synchronous active-low reset
//  en, dir     : count enable, direction (1 = up, 0 = down)
//  load        : synchronous load strobe, load_val clamped to MAX
//  count       : registered count
//  wrap        : registered 1-cycle terminal pulse, coincident with the new count
//  next_count  : combinational next-state count (lets the top register a coincident all-zero flag)
module counter_chan
    import counter_pkg::*;
#(
    parameter int W        = 10,
    parameter int MAX      = 2**(W-1)-1,
    parameter int SATURATE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic [W-1:0] next_count
);

    dir_e         cur_dir;
    logic [W-1:0] clamped;
    logic [W:0]   sum_up;
    logic [W:0]   sum_dn;
    logic         at_max;
    logic         at_zero;
    logic         next_wrap;

    assign cur_dir = dir_e'(dir);
    assign clamped = W'(clamp_max(32'(load_val), 32'(MAX)));

    // One extra bit: a carry past MAX or a borrow below zero marks the terminal case.
    assign sum_up  = {1'b0, count} + 1'b1;
    assign sum_dn  = {1'b0, count} - 1'b1;
    assign at_max  = (sum_up > (W+1)'(MAX));
    assign at_zero = sum_dn[W];

    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        if (load) begin
            next_count = clamped;
        end else if (en) begin
            if (cur_dir == DIR_UP) begin
                if (at_max) begin
                    next_wrap  = 1'b1;
                    next_count = (SATURATE != 0) ? count : '0;
                end else begin
                    next_count = sum_up[W-1:0];
                end
            end else begin
                if (at_zero) begin
                    next_wrap  = 1'b1;
                    next_count = (SATURATE != 0) ? '0 : W'(MAX);
                end else begin
                    next_count = sum_dn[W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= next_wrap;
        end
    end

`ifdef FORMAL
    logic         prev_live;
    logic         prev_dir;
    logic         prev_load;
    logic [W-1:0] prev_count;

    always_ff @(posedge clk) begin
        prev_live  <= rst_n;
        prev_dir   <= dir;
        prev_load  <= load;
        prev_count <= count;
    end

    always_comb begin
        if (rst_n) begin
            a_range: assert (count <= W'(MAX));
            if (wrap && prev_dir && SATURATE == 0)
                a_wrapup: assert (count == '0);
            if (wrap && !prev_dir && SATURATE == 0)
                a_wrapdn: assert (count == W'(MAX));
            if (SATURATE != 0 && prev_live && !prev_load)
                a_sat: assert (!((prev_count == '0 && count == W'(MAX)) ||
                                 (prev_count == W'(MAX) && count == '0)));
        end
    end
`endif

endmodule

// File: rtl/mode_counter_bank.sv
// mode_counter_bank - bank of NCH independent modulo/saturating counters
//  clk, rst_n : clock, synchronous active-low reset
//  en, dir    : per-channel enable and direction (1 = up)
//  load       : per-channel load strobe, load_val channel i at [i*W +: W]
//  count      : per-channel counts, channel i at [i*W +: W]
//  wrap       : per-channel registered terminal pulses
//  all_zero   : registered, high when every channel count is zero
module mode_counter_bank
    import counter_pkg::*;
#(
    parameter int W        = 10,
    parameter int NCH      = 4,
    parameter int MAX      = 2**(W-1)-1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   dir,
    input  logic [NCH-1:0]   load,
    input  logic [NCH*W-1:0] load_val,
    output logic [NCH*W-1:0] count,
    output logic [NCH-1:0]   wrap,
    output logic             all_zero
);

    logic [NCH*W-1:0] next_flat;

    for (genvar i = 0; i < NCH; i++) begin : gen_chan
        counter_chan #(
            .W        (W),
            .MAX      (MAX),
            .SATURATE (SATURATE)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en[i]),
            .dir        (dir[i]),
            .load       (load[i]),
            .load_val   (load_val[i*W +: W]),
            .count      (count[i*W +: W]),
            .wrap       (wrap[i]),
            .next_count (next_flat[i*W +: W])
        );
    end

    // Registered from next-state counts so the flag lines up with count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            all_zero <= 1'b1;
        end else begin
            all_zero <= (next_flat == '0);
        end
    end

`ifdef FORMAL
    logic f_init_done = 1'b0;

    always_ff @(posedge clk) begin
        f_init_done <= 1'b1;
    end

    always_comb begin
        a_init: assume (!rst_n == !f_init_done);
        if (rst_n)
            a_zero: assert (all_zero == (count == '0));
    end
`endif

endmodule

// File: tb/tb_mode_counter_bank.sv
// tb/tb_mode_counter_bank.sv - self-checking bench for mode_counter_bank (wrap and saturate instances)
module tb_mode_counter_bank;

    localparam int W   = 10;
    localparam int NCH = 4;
    localparam int MAX = 511;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   en, dir, load;
    logic [NCH*W-1:0] load_val;
    logic [NCH*W-1:0] count_a, count_s;
    logic [NCH-1:0]   wrap_a, wrap_s;
    logic             az_a, az_s;

    int tests = 0;
    int fails = 0;
    int m_cnt [2][NCH];
    int m_wrap[2][NCH];

    always #5 clk = ~clk;

    mode_counter_bank #(.W(W), .NCH(NCH), .SATURATE(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .count(count_a), .wrap(wrap_a), .all_zero(az_a)
    );

    mode_counter_bank #(.W(W), .NCH(NCH), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .count(count_s), .wrap(wrap_s), .all_zero(az_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour: reset > load > en > hold, on plain integers.
    task automatic model_update();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NCH; i++) begin
                int lv;
                lv = int'(load_val[i*W +: W]);
                if (!rst_n) begin
                    m_cnt[s][i] = 0; m_wrap[s][i] = 0;
                end else if (load[i]) begin
                    m_cnt[s][i] = (lv > MAX) ? MAX : lv; m_wrap[s][i] = 0;
                end else if (en[i] && dir[i]) begin
                    if (m_cnt[s][i] == MAX) begin
                        m_wrap[s][i] = 1; m_cnt[s][i] = (s == 1) ? MAX : 0;
                    end else begin
                        m_wrap[s][i] = 0; m_cnt[s][i] = m_cnt[s][i] + 1;
                    end
                end else if (en[i]) begin
                    if (m_cnt[s][i] == 0) begin
                        m_wrap[s][i] = 1; m_cnt[s][i] = (s == 1) ? 0 : MAX;
                    end else begin
                        m_wrap[s][i] = 0; m_cnt[s][i] = m_cnt[s][i] - 1;
                    end
                end else begin
                    m_wrap[s][i] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        for (int s = 0; s < 2; s++) begin
            int zero_cnt;
            zero_cnt = 0;
            for (int i = 0; i < NCH; i++) begin
                logic [W-1:0] c;
                logic         w;
                c = (s == 1) ? count_s[i*W +: W] : count_a[i*W +: W];
                w = (s == 1) ? wrap_s[i] : wrap_a[i];
                check($sformatf("s%0d_count%0d", s, i), 32'(c), 32'(m_cnt[s][i]));
                check($sformatf("s%0d_wrap%0d", s, i), 32'(w), 32'(m_wrap[s][i]));
                if (m_cnt[s][i] == 0) zero_cnt++;
            end
            check($sformatf("s%0d_all_zero", s), 32'((s == 1) ? az_s : az_a),
                  32'(zero_cnt == NCH));
        end
    endtask

    task automatic set_ch(input int i, input logic e, input logic d, input logic l, input int v);
        en[i] = e; dir[i] = d; load[i] = l; load_val[i*W +: W] = W'(v);
    endtask

    initial begin
        rst_n = 1'b0; en = '0; dir = '0; load = '0; load_val = '0;
        step(); step();
        check("reset_count", 32'(count_a), 32'(0));
        check("reset_all_zero", 32'(az_a), 32'(1));
        rst_n = 1'b1;

        // Up count on ch0 to MAX, then wrap.
        set_ch(0, 1, 1, 0, 0);
        for (int k = 0; k < 511; k++) step();
        check("t1_count0_max", 32'(count_a[9:0]), 32'(511));
        step();
        check("t1_count0_wrap0", 32'(count_a[9:0]), 32'(0));
        check("t1_wrap0_hi", 32'(wrap_a[0]), 32'(1));
        set_ch(0, 0, 1, 0, 0);
        step();
        check("t1_wrap0_lo", 32'(wrap_a[0]), 32'(0));

        // Down from zero on ch1.
        set_ch(1, 1, 0, 0, 0);
        step();
        check("t2_count1_max", 32'(count_a[19:10]), 32'(511));
        check("t2_wrap1_hi", 32'(wrap_a[1]), 32'(1));
        step();
        check("t2_count1_510", 32'(count_a[19:10]), 32'(510));
        check("t2_wrap1_lo", 32'(wrap_a[1]), 32'(0));
        set_ch(1, 0, 0, 0, 0);

        // Over-range load clamps; en ignored during load.
        set_ch(2, 1, 1, 1, 1000);
        step();
        check("t3_count2_clamp", 32'(count_a[29:20]), 32'(511));
        check("t3_wrap2_lo", 32'(wrap_a[2]), 32'(0));
        set_ch(2, 1, 1, 0, 0);
        step();
        check("t3_count2_wrap", 32'(count_a[29:20]), 32'(0));
        check("t3_wrap2_hi", 32'(wrap_a[2]), 32'(1));
        set_ch(2, 0, 1, 0, 0);

        // Saturation on ch0.
        set_ch(0, 0, 1, 1, 510);
        step();
        set_ch(0, 1, 1, 0, 0);
        step();
        check("t4_sat_511", 32'(count_s[9:0]), 32'(511));
        check("t4_sat_wrap_lo", 32'(wrap_s[0]), 32'(0));
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_sat_hold_max", 32'(count_s[9:0]), 32'(511));
            check("t4_sat_wrap_hi", 32'(wrap_s[0]), 32'(1));
        end
        set_ch(0, 0, 1, 1, 0);
        step();
        set_ch(0, 1, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            step();
            check("t4_sat_hold_zero", 32'(count_s[9:0]), 32'(0));
            check("t4_sat_dn_wrap", 32'(wrap_s[0]), 32'(1));
        end

        // all_zero rises with the last channel reaching zero.
        for (int i = 0; i < NCH; i++) set_ch(i, 0, 0, 1, (i == 3) ? 5 : 0);
        step();
        for (int i = 0; i < NCH; i++) set_ch(i, 0, 0, 0, 0);
        set_ch(3, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t5_all_zero", 32'(az_a), 32'(k == 4));
        end
        set_ch(3, 0, 0, 0, 0);

        // Reset beats load and en.
        for (int i = 0; i < NCH; i++) set_ch(i, 1, 1, 0, 100);
        step(); step();
        load = '1; rst_n = 1'b0;
        step();
        check("t6_count_a", 32'(count_a), 32'(0));
        check("t6_count_s", 32'(count_s), 32'(0));
        check("t6_wrap", 32'({wrap_a, wrap_s}), 32'(0));
        check("t6_all_zero", 32'({az_a, az_s}), 32'(3));
        rst_n = 1'b1; load = '0;

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < NCH; i++) begin
                set_ch(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 15) == 0), int'($urandom_range(0, 1023)));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
